// File: rtl/classificador_cores_cubo.sv
// classificador_cores_cubo
// Accumulates RGB565 samples per cube-face quadrant (9 quadrants), averages
// each quadrant by shifting by LOG2_AMOSTRAS and maps the average to one of
// six sticker colours. The packed 27-bit result is published with a one-cycle
// pronto pulse.
// Optional feature macro: VALIDA_AMOSTRAS_EN -- when defined, a quadrant that
// did not collect the full 2^LOG2_AMOSTRAS samples is reported as invalido (7).
module classificador_cores_cubo #(
  parameter int LOG2_AMOSTRAS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        pixel_valido,
  input  logic [15:0] pixel,
  input  logic [3:0]  quadrante,
  input  logic        fim_frame,
  output logic [26:0] cores,
  output logic        pronto,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam int N  = LOG2_AMOSTRAS;
  localparam int NQ = 9;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ACUMULA    = 2'd1,
    CLASSIFICA = 2'd2,
    FIM        = 2'd3
  } estado_t;

  estado_t      state_q, state_d;
  logic [3:0]   idx_q;
  logic [26:0]  staging_q;
  logic [26:0]  cores_q;
  logic         pronto_q;
  logic         ocupado_q;

  // Per-quadrant sums, exposed as arrays for the classification mux
  logic [N+4:0] sum_r_w [NQ];
  logic [N+5:0] sum_g_w [NQ];
  logic [N+4:0] sum_b_w [NQ];
`ifdef VALIDA_AMOSTRAS_EN
  logic         cheio_w [NQ];
`endif

  // A pixel is only taken while accumulating and not being restarted
  logic aceita_pixel;
  assign aceita_pixel = (state_q == ACUMULA) && !iniciar && pixel_valido;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_quad
    logic [N:0]   cnt_q;
    logic [N+4:0] sum_r_q;
    logic [N+5:0] sum_g_q;
    logic [N+4:0] sum_b_q;
    logic         hit;

    // The counter's top bit doubles as the saturation flag (count == 2^N)
    assign hit = aceita_pixel && (quadrante == 4'(gi)) && !cnt_q[N];

    // Accumulate this quadrant's samples until 2^N have been seen
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        sum_r_q <= '0;
        sum_g_q <= '0;
        sum_b_q <= '0;
      end else if (iniciar) begin
        cnt_q   <= '0;
        sum_r_q <= '0;
        sum_g_q <= '0;
        sum_b_q <= '0;
      end else if (hit) begin
        cnt_q   <= cnt_q + 1'b1;
        sum_r_q <= sum_r_q + (N+5)'(pixel[15:11]);
        sum_g_q <= sum_g_q + (N+6)'(pixel[10:5]);
        sum_b_q <= sum_b_q + (N+5)'(pixel[4:0]);
      end
    end

    assign sum_r_w[gi] = sum_r_q;
    assign sum_g_w[gi] = sum_g_q;
    assign sum_b_w[gi] = sum_b_q;
`ifdef VALIDA_AMOSTRAS_EN
    assign cheio_w[gi] = cnt_q[N];
`endif
  end

  // Average and classify the quadrant currently selected by idx_q
  logic [N+4:0] avg_r_full, avg_b_full;
  logic [N+5:0] avg_g_full;
  logic [4:0]   r5, b5;
  logic [5:0]   g6;
  logic [7:0]   r8, g8, b8;
  logic [2:0]   code;

  // Shift-average, expand to 8 bits, then apply the colour rules in priority order
  always_comb begin
    avg_r_full = sum_r_w[idx_q] >> N;
    avg_g_full = sum_g_w[idx_q] >> N;
    avg_b_full = sum_b_w[idx_q] >> N;
    r5 = avg_r_full[4:0];
    g6 = avg_g_full[5:0];
    b5 = avg_b_full[4:0];
    r8 = {r5, r5[4:2]};
    g8 = {g6, g6[5:4]};
    b8 = {b5, b5[4:2]};
    if (r8 >= 8'd160 && g8 >= 8'd160 && b8 >= 8'd160)      code = 3'd0; // branco
    else if (r8 >= 8'd160 && g8 >= 8'd160 && b8 < 8'd120)  code = 3'd1; // amarelo
    else if (b8 > r8 && b8 > g8)                           code = 3'd5; // azul
    else if (g8 > r8 && g8 >= b8)                          code = 3'd4; // verde
    else if (r8 >= 8'd128 && g8 >= 8'd80)                  code = 3'd3; // laranja
    else                                                   code = 3'd2; // vermelho
`ifdef VALIDA_AMOSTRAS_EN
    if (!cheio_w[idx_q]) code = 3'd7;
`endif
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  // Next-state logic; iniciar restarts from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:     if (iniciar) state_d = ACUMULA;
      ACUMULA:    if (iniciar) state_d = ACUMULA;
                  else if (fim_frame) state_d = CLASSIFICA;
      CLASSIFICA: if (iniciar) state_d = ACUMULA;
                  else if (idx_q == 4'd8) state_d = FIM;
      FIM:        state_d = iniciar ? ACUMULA : OCIOSO;
      default:    state_d = OCIOSO;
    endcase
  end

  // Classification sweep, result publication and registered status outputs.
  // ocupado follows the state one cycle late so it is already low when
  // pronto fires, even if iniciar arrives in FIM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      staging_q <= '0;
      cores_q   <= 27'h7FFFFFF;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      ocupado_q <= (state_q == ACUMULA) || (state_q == CLASSIFICA);
      pronto_q  <= (state_q == FIM);
      if (state_q == FIM) cores_q <= staging_q;
      if (state_q == CLASSIFICA) begin
        staging_q[3*idx_q +: 3] <= code;
        idx_q                   <= idx_q + 4'd1;
      end else begin
        idx_q <= '0;
      end
    end
  end

  assign cores     = cores_q;
  assign pronto    = pronto_q;
  assign ocupado   = ocupado_q;
  assign db_estado = {2'b00, state_q};

endmodule

// File: doc/classificador_cores_cubo.md
# classificador_cores_cubo

Downstream stage of the OV7670 capture interface: consumes its RGB565 pixel stream, split by quadrant, and classifies the sticker colour of each of the nine quadrants of one cube face. It accumulates R, G and B sums per quadrant over a fixed number of samples, averages them by shift, and maps each average to one of six cube colours. The packed result goes to the face-state logic, delivered with a one-cycle `pronto` pulse.

## Interface
- `LOG2_AMOSTRAS`, default 8: samples averaged per quadrant = 2^LOG2_AMOSTRAS.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `iniciar` in 1: single-cycle pulse; clears accumulators and starts a capture.
- `pixel_valido` in 1: `pixel`/`quadrante` valid this cycle.
- `pixel` in 16: RGB565, R=[15:11], G=[10:5], B=[4:0].
- `quadrante` in 4: quadrant index 0..8; values 9..15 are ignored.
- `fim_frame` in 1: single-cycle pulse, end of face frame.
- `cores` out 27: 3-bit colour code per quadrant, q at [3q+2:3q].
- `pronto` out 1: one-cycle pulse when `cores` has been updated.
- `ocupado` out 1: high in ACUMULA and CLASSIFICA.
- `db_estado` out 4: current state code.

## Operation
- Colour codes: 0 branco, 1 amarelo, 2 vermelho, 3 laranja, 4 verde, 5 azul, 7 invalido; 6 is never produced.
- States (db_estado): OCIOSO=0, ACUMULA=1, CLASSIFICA=2, FIM=3.
- OCIOSO, on `iniciar`:
  - clear all 9 sample counters and sums;
  - go to ACUMULA.
- ACUMULA, on `pixel_valido` with `quadrante`<9:
  - if that quadrant's counter < 2^N, add R to its 5+N-bit sum, G to its 6+N-bit sum, B to its 5+N-bit sum, and increment its counter;
  - otherwise ignore the pixel (the counter saturates).
- ACUMULA, on `fim_frame`: go to CLASSIFICA. A pixel valid in the same cycle is accumulated first.
- CLASSIFICA: one quadrant per cycle, index 0..8, result written to an internal staging register. Steps for each quadrant:
  - Average by shift: r=sumR>>N, g=sumG>>N, b=sumB>>N.
  - Expand to 8 bits: r8={r,r[4:2]}, g8={g,g[5:4]}, b8={b,b[4:2]}.
  - Rules, first match wins:
    1. r8≥160, g8≥160, b8≥160 → branco
    2. r8≥160, g8≥160, b8<120 → amarelo
    3. b8>r8 and b8>g8 → azul
    4. g8>r8 and g8≥b8 → verde
    5. r8≥128 and g8≥80 → laranja
    6. otherwise → vermelho
- After index 8, go to FIM.
- FIM (one cycle):
  - `cores` loads the staging register atomically;
  - `pronto`=1;
  - go to OCIOSO.
- `iniciar` in ACUMULA or CLASSIFICA: restart (clear, go to ACUMULA). No `pronto`; `cores` unchanged.
- `fim_frame` outside ACUMULA is ignored. `pixel_valido` outside ACUMULA is ignored.
- `iniciar` in FIM: `pronto` still fires; the next state is ACUMULA (accumulators cleared).

## Timing
- Reset values:
  - state OCIOSO, `db_estado`=0;
  - `cores`=27'h7FFFFFF (all invalido);
  - `pronto`=0, `ocupado`=0;
  - counters, sums and staging register = 0.
- Reset asserted mid-operation aborts immediately to the reset values.
- `iniciar` sampled at edge E: ACUMULA from E; first pixel accepted at E+1.
- `fim_frame` sampled at edge F:
  - CLASSIFICA during the 9 cycles after F;
  - `cores` changes and `pronto` rises at edge F+10;
  - `pronto` falls at F+11.
- `ocupado` is registered from state; it is never high together with `pronto`.

## Configuration
- `VALIDA_AMOSTRAS_EN` defined: a quadrant whose counter < 2^N at classification gets code 7 (invalido).
- `VALIDA_AMOSTRAS_EN` undefined: every quadrant is classified from sum>>N regardless of count. Short quadrants read darker; code 7 never appears after the first `pronto`.

## Test plan
- Reset then idle → `cores`=27'h7FFFFFF, `pronto`=0, `db_estado`=0; `fim_frame` alone produces no `pronto`.
- N=2. `iniciar`, then 4 pixels 16'hFFFF to every quadrant, then `fim_frame` → `pronto` exactly 10 cycles after the F edge; `cores`=0 (all branco).
- N=2. Distinct colours per quadrant: q0 16'hF800 vermelho, q1 16'hFC00 laranja, q2 16'hFFE0 amarelo, q3 16'h07E0 verde, q4 16'h001F azul, q5..q8 16'hFFFF → codes 2,3,1,4,5,0,0,0,0.
- N=2. Quadrant 4 receives only 3 pixels, others full; run with and without `VALIDA_AMOSTRAS_EN` → q4 code 7 with the macro; without it, q4 is classified from sum>>2.
- Overflow and ignores: 10 pixels to q0 (only the first 4 counted); `quadrante`=12 pixels ignored; `pixel_valido` and `fim_frame` in the same cycle → that pixel counted.
- Restarts: `iniciar` during CLASSIFICA → no `pronto`, `cores` unchanged, `db_estado`=1. Async reset low during ACUMULA → all outputs return to reset values without waiting for a clock edge.
